// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: byte-stream side of the host UART receiver.
// Groups the serial input, the valid/ready byte handshake and the status
// pulses. The optional error-statistics signals exist only when
// UART_RX_ERR_STATS_EN is defined.
// Modport "slave" is the receiver itself; "master" is its environment
// (line driver plus byte consumer).
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8
) ();
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rx;
  logic [7:0]    data_out;
  logic          data_valid;
  logic          data_ready;
  logic [CW-1:0] fifo_count;
  logic          frame_err;
  logic          overflow;
`ifdef UART_RX_ERR_STATS_EN
  logic [15:0]   err_count;
  logic          err_clear;

  modport slave (
    input  rx, data_ready, err_clear,
    output data_out, data_valid, fifo_count, frame_err, overflow, err_count
  );
  modport master (
    output rx, data_ready, err_clear,
    input  data_out, data_valid, fifo_count, frame_err, overflow, err_count
  );
`else
  modport slave (
    input  rx, data_ready,
    output data_out, data_valid, fifo_count, frame_err, overflow
  );
  modport master (
    output rx, data_ready,
    input  data_out, data_valid, fifo_count, frame_err, overflow
  );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver (LSB first) feeding a small
// first-word-fall-through byte FIFO with a valid/ready read side.
// Optional feature macro: UART_RX_ERR_STATS_EN adds saturating frame-error
// and overflow counters (err_count) with a synchronous clear (err_clear).
module uart_rx_fifo #(
  parameter int BAUD_DIV   = 174,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int BW      = $clog2(BAUD_DIV);
  localparam int HALF_M1 = BAUD_DIV / 2 - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  // ---------------- input synchroniser ----------------
  logic rx_meta_q;
  logic rxs_q;

  // Two-flop synchroniser; both stages idle high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // ---------------- receive FSM ----------------
  state_t        state_q;
  logic [BW-1:0] baud_cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          frame_err_q;
  logic          half_tick;
  logic          bit_tick;
  logic          push_w;

  assign half_tick = (baud_cnt_q == BW'(HALF_M1));
  assign bit_tick  = (baud_cnt_q == BW'(BAUD_DIV - 1));
  // A good stop bit writes the byte at the stop-sample edge itself.
  assign push_w    = (state_q == S_STOP) && bit_tick && rxs_q;

  // Frame sequencer: baud counter restarts at every sample point; frame_err is a registered pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      baud_cnt_q  <= baud_cnt_q + BW'(1);
      case (state_q)
        S_IDLE: begin
          baud_cnt_q <= '0;
          if (!rxs_q) begin
            state_q   <= S_START;
            bit_cnt_q <= '0;
          end
        end
        S_START: begin
          if (half_tick) begin
            baud_cnt_q <= '0;
            // A line that is high again at mid-start-bit was only a glitch.
            state_q    <= rxs_q ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            baud_cnt_q <= '0;
            shift_q    <= {rxs_q, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            baud_cnt_q <= '0;
            if (rxs_q) begin
              state_q <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BRK;
            end
          end
        end
        S_BRK: begin
          // Hold here through a break so it yields a single frame_err.
          baud_cnt_q <= '0;
          if (rxs_q) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- byte FIFO ----------------
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        overflow_q;
  logic        empty_w;
  logic        full_w;
  logic        pop_w;
  logic        push_ok_w;

  assign empty_w   = (wr_ptr_q == rd_ptr_q);
  assign full_w    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop_w     = !empty_w && bus.data_ready;
  // When full, a same-cycle pop frees the head slot, so the push still fits.
  assign push_ok_w = push_w && (!full_w || pop_w);

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok_w) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end
  end

  // Pointer and overflow-pulse update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok_w) begin
        wr_ptr_q <= wr_ptr_q + CW'(1);
      end
      if (pop_w) begin
        rd_ptr_q <= rd_ptr_q + CW'(1);
      end
      overflow_q <= push_w && full_w && !pop_w;
    end
  end

  assign bus.data_out   = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.data_valid = !empty_w;
  assign bus.fifo_count = wr_ptr_q - rd_ptr_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overflow   = overflow_q;

`ifdef UART_RX_ERR_STATS_EN
  // ---------------- error statistics ----------------
  logic [7:0] fe_cnt_q;
  logic [7:0] ov_cnt_q;

  // Saturating pulse counters; a clear wins over a coincident pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fe_cnt_q <= '0;
      ov_cnt_q <= '0;
    end else if (bus.err_clear) begin
      fe_cnt_q <= '0;
      ov_cnt_q <= '0;
    end else begin
      if (frame_err_q && (fe_cnt_q != 8'hFF)) begin
        fe_cnt_q <= fe_cnt_q + 8'd1;
      end
      if (overflow_q && (ov_cnt_q != 8'hFF)) begin
        ov_cnt_q <= ov_cnt_q + 8'd1;
      end
    end
  end

  assign bus.err_count = {ov_cnt_q, fe_cnt_q};
`endif

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Host-side serial receiver that converts the USB UART line (8N1, LSB first) into a byte stream and hands it to `ice_bus` through a valid/ready interface. It sits directly upstream of the bus controller's host-command parser, on the `clk` domain. It provides input synchronisation, start-bit glitch rejection, framing-error detection, and a small first-word-fall-through FIFO that absorbs parser stalls.

## Interface
- `BAUD_DIV`, default 174: `clk` cycles per bit. Minimum 4.
- `FIFO_DEPTH`, default 8: byte entries. Must be a power of 2, at least 2.
- `clk`  in  1  system clock (global buffered).
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line from the host. Idle high; asynchronous to `clk`.
- `data_out`  out  8  head-of-FIFO byte. Meaningful only while `data_valid` is high.
- `data_valid`  out  1  FIFO not empty.
- `data_ready`  in  1  consumer accepts the head byte when high together with `data_valid`.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of bytes currently held.
- `frame_err`  out  1  one-cycle pulse when a stop bit samples low.
- `overflow`  out  1  one-cycle pulse when a received byte is dropped because the FIFO is full.

## Operation
- **Synchroniser:** two flops on `rx`, both reset to 1. All logic uses the synchronised output `rxs`.
- **FSM states:** IDLE, START, DATA, STOP, BRK.
  - IDLE: when `rxs`=0, go to START and clear the bit counter.
  - START: after `BAUD_DIV/2` cycles (floor), sample `rxs`. If 0, go to DATA. If 1, treat it as a glitch and return to IDLE with nothing reported.
  - DATA: every `BAUD_DIV` cycles, sample one bit into a shift register, LSB first. After the 8th sample, go to STOP.
  - STOP: after `BAUD_DIV` cycles, sample `rxs`.
    - If 1: push the byte and go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, and go to BRK.
  - BRK: wait for `rxs`=1, then go to IDLE. A held-low break therefore produces exactly one `frame_err`.
- **FIFO:** circular buffer with read and write pointers one bit wider than the address.
  - First-word-fall-through: `data_out` = `mem[rd_ptr]` at all times.
  - Pop occurs when `data_valid && data_ready`. `data_ready` while empty has no effect.
  - Push occurs when the stop bit is good. If the FIFO is full and no pop happens in the same cycle, drop the byte and pulse `overflow`.
  - If the FIFO is full and a pop happens in the same cycle, the push is accepted, `fifo_count` stays at `FIFO_DEPTH`, and there is no `overflow`.
  - Simultaneous push and pop at any other count leaves `fifo_count` unchanged.
- **Pointer wrap:** pointers wrap modulo 2·`FIFO_DEPTH`. Full is when the addresses are equal and the MSBs differ; empty is when the pointers are equal.
- **Reset mid-frame:** the FSM returns to IDLE, the partial byte is lost, the FIFO empties, and all pulses clear.
- **Reset values:** `data_valid`=0, `fifo_count`=0, `frame_err`=0, `overflow`=0. `data_out` is don't-care because memory is not reset; the pointers are.

## Timing
- Let t0 be the first cycle with `rxs`=0 in IDLE (2–3 cycles after the `rx` edge, due to the synchroniser).
- Sample points, relative to t0:
  - start bit: t0+`BAUD_DIV/2`
  - data bit n (n=0..7): t0+`BAUD_DIV/2`+(n+1)·`BAUD_DIV`
  - stop bit: t0+`BAUD_DIV/2`+9·`BAUD_DIV`
- The push is registered at the stop-sample cycle. `data_valid` and the updated `fifo_count` are visible the next cycle.
- `frame_err` and `overflow` are asserted in the cycle after the stop sample, for exactly 1 cycle.
- A pop updates `data_out`, `data_valid` and `fifo_count` on the next edge. Sustained throughput is one byte per cycle on the read side.
- Back-to-back frames:
  - A new start bit may begin immediately after the stop-sample cycle; IDLE is re-entered that cycle.
  - Tolerated baud mismatch is ±4% at the default `BAUD_DIV`.

## Configuration
- `UART_RX_ERR_STATS_EN` defined:
  - Adds output `err_count`, 16 bits, packed as {overflow count[7:0], frame error count[7:0]}.
  - Adds input `err_clear`, 1 bit, synchronous.
  - Each counter saturates at 0xFF and increments on its pulse.
  - `err_clear` zeroes both counters; a pulse in the same cycle as `err_clear` is not counted.
  - Both counters reset to 0.
- `UART_RX_ERR_STATS_EN` undefined: neither port exists and no counter logic is instantiated. All other behaviour is identical.

## Test plan
- `BAUD_DIV`=8: send 0xA5 (8N1) with `data_ready`=1 → `data_out`=0xA5 with `data_valid` high for 1 cycle, exactly 1 cycle after the stop sample; `frame_err`=0.
- Glitch: `rx` low for 2 cycles in IDLE, then high → no byte, no `frame_err`, FSM back in IDLE.
- Framing error: 0x3C with stop bit 0, then line held low for 40 bits → one `frame_err` pulse, FIFO empty. A following valid 0x11 is received correctly.
- Overflow: `FIFO_DEPTH`=4, `data_ready`=0, send 0x01–0x05 → `fifo_count`=4, one `overflow` pulse on the 5th byte; draining yields 0x01, 0x02, 0x03, 0x04.
- Full plus same-cycle pop: hold `fifo_count`=4, time `data_ready` to coincide with the 5th push → no `overflow`, count stays 4, last byte read out is the 5th.
- Reset mid-frame: assert `reset` during bit 4 of 0xFF → all outputs at reset values; the next frame 0x5A is received intact.
